// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed hex driver for a common-anode multi-digit 7-segment display.
//   Scans one digit per slot of TICK_DIV cycles, blanking all enables for the first
//   BLANK_CYCLES cycles of each slot. New data is double-buffered and swapped in only
//   at a frame boundary, so a frame never mixes old and new digits.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   load                1-cycle strobe capturing value/dp_in/lz_en into the shadow regs
//   value               hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in               decimal point per digit, 1 = lit
//   lz_en               1 = suppress leading zeros
//   SevenSegment        segments g..a (bit6 = g), active-low
//   dp                  decimal point, active-low
//   SevenSegmentEnable  digit enables, active-low, bit i = digit i
//   frame_done          1-cycle pulse after the last digit slot ends
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [6:0]              SevenSegment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   SevenSegmentEnable,
  output logic                    frame_done
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d, shad_val_q, shad_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, shad_dp_q, shad_dp_d;
  logic                    disp_lz_q, disp_lz_d, shad_lz_q, shad_lz_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_wrap, frame_end, blank, zero_run, cur_dp, cur_sup;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   suppress;

  always_comb begin
    slot_wrap = (cnt_q == CntLast);
    frame_end = slot_wrap && (idx_q == IdxLast);

    cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    // A load on the frame-end cycle takes priority: it refreshes the shadow and
    // keeps pending set, deferring the swap to the next frame end.
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    shad_lz_d  = shad_lz_q;
    pending_d  = pending_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    disp_lz_d  = disp_lz_q;
    if (load) begin
      shad_val_d = value;
      shad_dp_d  = dp_in;
      shad_lz_d  = lz_en;
      pending_d  = 1'b1;
    end else if (frame_end && pending_q) begin
      disp_val_d = shad_val_q;
      disp_dp_d  = shad_dp_q;
      disp_lz_d  = shad_lz_q;
      pending_d  = 1'b0;
    end

    // Digit i is suppressed when it and every digit above it are zero; digit 0 never is.
    suppress = '0;
    zero_run = disp_lz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (disp_val_q[4*i +: 4] == 4'h0);
      suppress[i] = zero_run;
    end

    cur_nib = disp_val_q[3:0];
    cur_dp  = disp_dp_q[0];
    cur_sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = disp_val_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
        cur_sup = suppress[i];
      end
    end

    blank = (cnt_q < CntBlank);
    seg_d = (blank || cur_sup) ? 7'h7F : hex7(cur_nib);
    dp_d  = blank ? 1'b1 : ~cur_dp;
    en_d  = '1;
    if (!blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IdxW'(i)) en_d[i] = 1'b0;
      end
    end
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_lz_q    <= 1'b0;
      shad_val_q   <= '0;
      shad_dp_q    <= '0;
      shad_lz_q    <= 1'b0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      en_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      shad_val_q   <= shad_val_d;
      shad_dp_q    <= shad_dp_d;
      shad_lz_q    <= shad_lz_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      en_q         <= en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SevenSegment       = seg_q;
  assign dp                 = dp_q;
  assign SevenSegmentEnable = en_q;
  assign frame_done         = frame_done_q;

endmodule
